// File: rtl/dab_phase_sequencer_if.sv
// Control and gate-pin bundle for dab_phase_sequencer.
// The sequencer takes the slave side; the control loop or bench drives the master side.
interface dab_phase_sequencer_if #(
  parameter int PHASE_W = 8
);
  logic               sync;
  logic               switch;
  logic [PHASE_W-1:0] phase;
  logic [3:0]         Sp;
  logic [3:0]         Ss;
  logic               trigger;
  logic               running;

  modport master (
    output sync, switch, phase,
    input  Sp, Ss, trigger, running
  );

  modport slave (
    input  sync, switch, phase,
    output Sp, Ss, trigger, running
  );
endinterface

// File: rtl/dab_phase_sequencer.sv
// Dual-active-bridge gate sequencer: primary and phase-lagged secondary full-bridge gates with dead time.
// Gates/trigger/running are registered one cycle after cnt; no backpressure. SYNC_RESYNC_EN: sync re-aligns a running period.
module dab_phase_sequencer #(
  parameter int PERIOD  = 100,
  parameter int DEAD    = 5,
  parameter int PHASE_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dab_phase_sequencer_if.slave bus
);
  localparam int HALF  = PERIOD / 2;
  localparam int CNT_W = $clog2(PERIOD);
  localparam int EXT_W = CNT_W + 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    RUN      = 2'd2,
    STOPPING = 2'd3
  } state_t;

  localparam cnt_t CNT_LAST = cnt_t'(PERIOD - 1);
  localparam cnt_t PH_MAX   = cnt_t'(HALF - 1);

  // Bit order {B_lo, B_hi, A_lo, A_hi}; each half-period opens with DEAD cycles of all-off.
  function automatic logic [3:0] gate_pat(input cnt_t c);
    logic [3:0] p;
    if (c < cnt_t'(DEAD))             p = 4'b0000;
    else if (c < cnt_t'(HALF))        p = 4'b1001;
    else if (c < cnt_t'(HALF + DEAD)) p = 4'b0000;
    else                              p = 4'b0110;
    return p;
  endfunction

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  cnt_t       phase_r_q, phase_r_d;
  logic       sec_en_q, sec_en_d;
  logic       sync_meta_q, sync_stable_q, sync_prev_q;
  logic [3:0] sp_q, sp_d;
  logic [3:0] ss_q, ss_d;
  logic       trig_q, trig_d;
  logic       run_q, run_d;

  logic             sync_evt;
  logic             active;
  cnt_t             phase_clamp;
  cnt_t             scnt;
  logic [EXT_W-1:0] scnt_raw;
  logic [EXT_W-1:0] scnt_ext;

  assign sync_evt = sync_stable_q & ~sync_prev_q;
  assign active   = (state_q == RUN) || (state_q == STOPPING);

  assign phase_clamp = (bus.phase > PHASE_W'(HALF - 1)) ? PH_MAX : cnt_t'(bus.phase);

  // Add PERIOD before subtracting so the lag never underflows, then fold back into range.
  assign scnt_raw = {1'b0, cnt_q} + EXT_W'(PERIOD) - {1'b0, phase_r_q};
  assign scnt_ext = (scnt_raw >= EXT_W'(PERIOD)) ? (scnt_raw - EXT_W'(PERIOD)) : scnt_raw;
  assign scnt     = scnt_ext[CNT_W-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_r_d = phase_r_q;
    sec_en_d  = sec_en_q;

    unique case (state_q)
      IDLE: begin
        if (bus.switch) state_d = ARMED;
      end
      ARMED: begin
        if (!bus.switch) begin
          state_d = IDLE;
        end else if (sync_evt) begin
          state_d   = RUN;
          cnt_d     = '0;
          phase_r_d = phase_clamp;
          sec_en_d  = 1'b0;
        end
      end
      RUN: begin
        if (!bus.switch) state_d = STOPPING;
        if (cnt_q == phase_r_q) sec_en_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          phase_r_d = phase_clamp;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
`ifdef SYNC_RESYNC_EN
        // A sync on the last count is just the natural wrap, so the secondary stays armed.
        if (sync_evt && (cnt_q != CNT_LAST)) begin
          cnt_d     = '0;
          phase_r_d = phase_clamp;
          sec_en_d  = 1'b0;
        end
`endif
      end
      STOPPING: begin
        if (cnt_q == phase_r_q) sec_en_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d  = IDLE;
          cnt_d    = '0;
          sec_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
    endcase
  end

  always_comb begin
    sp_d   = 4'b0000;
    ss_d   = 4'b0000;
    trig_d = 1'b0;
    run_d  = 1'b0;
    if (active) begin
      sp_d   = gate_pat(cnt_q);
      ss_d   = sec_en_q ? gate_pat(scnt) : 4'b0000;
      trig_d = (cnt_q == '0);
      run_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      phase_r_q     <= '0;
      sec_en_q      <= 1'b0;
      sync_meta_q   <= 1'b0;
      sync_stable_q <= 1'b0;
      sync_prev_q   <= 1'b0;
      sp_q          <= 4'b0000;
      ss_q          <= 4'b0000;
      trig_q        <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phase_r_q     <= phase_r_d;
      sec_en_q      <= sec_en_d;
      sync_meta_q   <= bus.sync;
      sync_stable_q <= sync_meta_q;
      sync_prev_q   <= sync_stable_q;
      sp_q          <= sp_d;
      ss_q          <= ss_d;
      trig_q        <= trig_d;
      run_q         <= run_d;
    end
  end

  assign bus.Sp      = sp_q;
  assign bus.Ss      = ss_q;
  assign bus.trigger = trig_q;
  assign bus.running = run_q;
endmodule

// File: tb/tb_dab_phase_sequencer.sv
// Directed bench for dab_phase_sequencer at PERIOD=100, DEAD=5; outputs sampled on the falling edge.
module tb_dab_phase_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dab_phase_sequencer_if #(.PHASE_W(8)) bus ();

  dab_phase_sequencer #(
    .PERIOD (100),
    .DEAD   (5),
    .PHASE_W(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [3:0] pat(input int c);
    logic [3:0] p;
    if (c < 5)       p = 4'b0000;
    else if (c < 50) p = 4'b1001;
    else if (c < 55) p = 4'b0000;
    else             p = 4'b0110;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_sp"},   bus.Sp, 4'b0000);
    chk({nm, "_ss"},   bus.Ss, 4'b0000);
    chk({nm, "_trig"}, {3'b000, bus.trigger}, 4'b0000);
    chk({nm, "_run"},  {3'b000, bus.running}, 4'b0000);
  endtask

  // Called on a falling edge one cycle after switch=1; returns on the falling edge showing cnt 0.
  task automatic start_run(input string nm);
    bus.sync = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk({nm, "_trig_early"}, {3'b000, bus.trigger}, 4'b0000);
    end
    @(negedge clk);
    chk({nm, "_trig_lat"}, {3'b000, bus.trigger}, 4'b0001);
    chk({nm, "_run_lat"},  {3'b000, bus.running}, 4'b0001);
    bus.sync = 1'b0;
  endtask

  // Ss is expected only for c > en_after (en_after = -1: secondary already armed).
  task automatic check_period(input string nm, input int start, input int stop, input int lag,
                              input int en_after, input int chg_at, input logic [7:0] chg_ph,
                              input int sw_off_at, input int sync_at);
    for (int c = start; c <= stop; c++) begin
      logic [3:0] ss_exp;
      ss_exp = (c > en_after) ? pat((c - lag + 100) % 100) : 4'b0000;
      chk($sformatf("%s_trig_c%0d", nm, c), {3'b000, bus.trigger}, (c == 0) ? 4'b0001 : 4'b0000);
      chk($sformatf("%s_sp_c%0d", nm, c), bus.Sp, pat(c));
      chk($sformatf("%s_ss_c%0d", nm, c), bus.Ss, ss_exp);
      chk($sformatf("%s_run_c%0d", nm, c), {3'b000, bus.running}, 4'b0001);
      if (c == chg_at) bus.phase = chg_ph;
      if (c == sw_off_at) bus.switch = 1'b0;
      if (sync_at >= 0 && c == sync_at) bus.sync = 1'b1;
      if (sync_at >= 0 && c == sync_at + 3) bus.sync = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.sync   = 1'b0;
    bus.switch = 1'b0;
    bus.phase  = 8'd0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle");
    bus.switch = 1'b1;
    @(negedge clk);

    start_run("t1");
    check_period("t1", 0, 99, 0, 0, 60, 8'd25, -1, -1);
    check_period("t2", 0, 99, 25, -1, 40, 8'd80, -1, -1);
    check_period("t3", 0, 99, 49, -1, -1, 8'd0, -1, -1);
    check_period("t4", 0, 99, 49, -1, -1, 8'd0, 30, -1);
    check_zero("t4_done");

    for (int i = 0; i < 24; i++) begin
      if (i % 8 == 0) bus.sync = 1'b1;
      if (i % 8 == 4) bus.sync = 1'b0;
      @(negedge clk);
      chk($sformatf("t4_idle_trig_%0d", i), {3'b000, bus.trigger}, 4'b0000);
      chk($sformatf("t4_idle_run_%0d", i),  {3'b000, bus.running}, 4'b0000);
    end

    bus.sync   = 1'b0;
    bus.phase  = 8'd25;
    bus.switch = 1'b1;
    @(negedge clk);
    start_run("t5");
    check_period("t5a", 0, 60, 25, 25, -1, 8'd0, -1, 57);
`ifdef SYNC_RESYNC_EN
    check_period("t5r", 0, 20, 25, 25, -1, 8'd0, -1, -1);
`else
    check_period("t5n", 61, 99, 25, 25, -1, 8'd0, -1, -1);
    check_period("t6pre", 0, 20, 25, -1, -1, 8'd0, -1, -1);
`endif

    chk("t6_sp_before", bus.Sp, 4'b1001);
    rst_n = 1'b0;
    #1;
    check_zero("t6_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_zero($sformatf("t6_after_%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
